// File: rtl/sr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sr_pkg
// Brief   : Shared state encoding and defaults for the start/stop command path.
// Rev     : 1.0  initial release
// ============================================================================
package sr_pkg;

  localparam logic [1:0] C_ST_IDLE = 2'b00;
  localparam logic [1:0] C_ST_RUN  = 2'b01;
  localparam logic [1:0] C_ST_HOLD = 2'b10;

  localparam int C_CNT_W_DEF = 4;

endpackage : sr_pkg
`default_nettype wire

// File: rtl/sr_debounce.sv
`default_nettype none
// ============================================================================
// Module  : sr_debounce
// Brief   : Button synchronizer, debouncer and press (rising-edge) detector.
// Rev     : 1.0  initial release
// ============================================================================
module sr_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [DEB_W-1:0] C_CNT_MAX = DEB_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [1:0]       fill_q, fill_d;
  logic             level_q, level_d;
  logic             level_d1_q, level_d1_d;
  logic             armed_q, armed_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d     = {sync_q[0], btn};
    fill_d     = {fill_q[0], 1'b1};
    level_d    = level_q;
    level_d1_d = level_q;
    cnt_d      = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == C_CNT_MAX) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A button held through reset must be seen released before it may fire.
    armed_d = armed_q | (fill_q[1] & ~sync_q[1] & ~level_q);
  end

  assign press = level_q & ~level_d1_q & armed_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q     <= '0;
      fill_q     <= '0;
      level_q    <= 1'b0;
      level_d1_q <= 1'b0;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      fill_q     <= fill_d;
      level_q    <= level_d;
      level_d1_q <= level_d1_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule : sr_debounce
`default_nettype wire

// File: rtl/sr_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module  : sr_cmd_gen
// Brief   : Push-button to start/stop/clr command pulse generator with run FSM.
//           Optional lap capture of count_in at stop: macro SR_LAP_CAPTURE_EN.
// Rev     : 1.0  initial release
// ============================================================================
module sr_cmd_gen
  import sr_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 3,
  parameter int CNT_W      = C_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic [CNT_W-1:0] count_in,
  output logic             start,
  output logic             stop,
  output logic             clr,
  output logic             running,
  output logic [CNT_W-1:0] lap_value,
  output logic             lap_valid
);

  logic       start_ev, stop_ev;
  logic [1:0] state_q, state_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       clr_q, clr_d;
  logic       running_q, running_d;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_start (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start),
    .press (start_ev)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_stop (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_stop),
    .press (stop_ev)
  );

  // Stop wins a same-cycle collision; the losing start is dropped.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    clr_d   = 1'b0;
    case (state_q)
      C_ST_IDLE: begin
        if (start_ev && !stop_ev) begin
          state_d = C_ST_RUN;
          start_d = 1'b1;
        end
      end
      C_ST_RUN: begin
        if (stop_ev) begin
          state_d = C_ST_HOLD;
          stop_d  = 1'b1;
        end
      end
      C_ST_HOLD: begin
        if (stop_ev) begin
          state_d = C_ST_IDLE;
          clr_d   = 1'b1;
        end else if (start_ev) begin
          state_d = C_ST_RUN;
          start_d = 1'b1;
        end
      end
      default: state_d = C_ST_IDLE;
    endcase
    running_d = (state_d == C_ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= C_ST_IDLE;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      clr_q     <= clr_d;
      running_q <= running_d;
    end
  end

  assign start   = start_q;
  assign stop    = stop_q;
  assign clr     = clr_q;
  assign running = running_q;

`ifdef SR_LAP_CAPTURE_EN
  logic [CNT_W-1:0] lap_value_q, lap_value_d;
  logic             lap_valid_q, lap_valid_d;

  always_comb begin
    lap_value_d = lap_value_q;
    lap_valid_d = stop_d;
    if (stop_d) begin
      lap_value_d = count_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lap_value_q <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_value_q <= lap_value_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_value = lap_value_q;
  assign lap_valid = lap_valid_q;
`else
  logic unused_count_in;
  assign unused_count_in = ^count_in;
  assign lap_value       = '0;
  assign lap_valid       = 1'b0;
`endif

endmodule : sr_cmd_gen
`default_nettype wire

// File: tb/tb_sr_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_sr_cmd_gen
// Brief   : Scoreboard bench for sr_cmd_gen; expected pulses queued at press
//           time and popped by a monitor whenever a command pulse appears.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sr_cmd_gen;

  localparam int DEB   = 4;
  localparam int CNT_W = 4;
`ifdef SR_LAP_CAPTURE_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             btn_start, btn_stop;
  logic [CNT_W-1:0] count_in;
  logic             start, stop, clr, running, lap_valid;
  logic [CNT_W-1:0] lap_value;

  typedef struct {
    logic [2:0]       cmd;
    int               cyc;
    logic             run;
    logic             lv;
    logic [CNT_W-1:0] lap;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               cyc = 0;
  int               total = 0;
  int               bad = 0;
  logic [CNT_W-1:0] exp_lap;

  sr_cmd_gen #(.DEB_CYCLES(DEB), .DEB_W(3), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .count_in  (count_in),
    .start     (start),
    .stop      (stop),
    .clr       (clr),
    .running   (running),
    .lap_value (lap_value),
    .lap_valid (lap_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every command or lap strobe must match the head of the queue.
  always @(negedge clk) begin
    if (start || stop || clr || lap_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: cyc=%0d got start/stop/clr=%b lap_valid=%b required no pulse",
                 cyc, {start, stop, clr}, lap_valid);
      end else begin
        mon_e = sb.pop_front();
        if ({start, stop, clr} !== mon_e.cmd || cyc != mon_e.cyc) begin
          bad++;
          $display("FAIL cmd_pulse: got cmd=%b at cyc=%0d required cmd=%b at cyc=%0d",
                   {start, stop, clr}, cyc, mon_e.cmd, mon_e.cyc);
        end
        total++;
        if ({running, lap_valid, lap_value} !== {mon_e.run, mon_e.lv, mon_e.lap}) begin
          bad++;
          $display("FAIL pulse_state: got running=%b lap_valid=%b lap_value=%h required running=%b lap_valid=%b lap_value=%h",
                   running, lap_valid, lap_value, mon_e.run, mon_e.lv, mon_e.lap);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press one button for 'hold' cycles; optionally queue the expected command.
  task automatic press(input bit is_stop, input int hold, input bit expect_ev,
                       input logic [2:0] cmd, input logic run, input logic lv);
    exp_t e;
    int   k;
    if (is_stop) btn_stop = 1'b1;
    else         btn_start = 1'b1;
    k = cyc + 1;
    if (expect_ev) begin
      e.cmd = cmd;
      e.cyc = k + DEB + 2;
      e.run = run;
      e.lv  = lv;
      e.lap = exp_lap;
      sb.push_back(e);
    end
    tick(hold);
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    tick(DEB + 8);
  endtask

  initial begin
    int k;
    reset     = 1'b0;
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    count_in  = '0;
    exp_lap   = '0;

    // 1: reset then idle
    tick(3);
    check("in_reset_outputs", 16'({start, stop, clr, running, lap_valid, lap_value}), 16'h0);
    reset = 1'b1;
    tick(20);
    check("idle_outputs", 16'({start, stop, clr, running, lap_valid, lap_value}), 16'h0);

    // 2: clean start press
    count_in = 4'h2;
    press(1'b0, 10, 1'b1, 3'b100, 1'b1, 1'b0);
    check("running_after_start", 16'(running), 16'h1);

    // 3: short glitch on stop, then a real stop with lap capture
    btn_stop = 1'b1;
    tick(2);
    btn_stop = 1'b0;
    tick(12);
    check("running_after_glitch", 16'(running), 16'h1);
    count_in = 4'h9;
    if (LAP) exp_lap = 4'h9;
    press(1'b1, 10, 1'b1, 3'b010, 1'b0, LAP);
    check("running_after_stop", 16'(running), 16'h0);

    // 4: resume, hold again, then clear
    count_in = 4'h5;
    press(1'b0, 10, 1'b1, 3'b100, 1'b1, 1'b0);
    count_in = 4'h3;
    if (LAP) exp_lap = 4'h3;
    press(1'b1, 10, 1'b1, 3'b010, 1'b0, LAP);
    count_in = 4'h7;
    press(1'b1, 10, 1'b1, 3'b001, 1'b0, 1'b0);
    check("lap_after_clr", 16'(lap_value), 16'(exp_lap));

    // 5: simultaneous press in IDLE -> nothing
    btn_start = 1'b1;
    btn_stop  = 1'b1;
    tick(10);
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    tick(12);
    check("running_after_both", 16'(running), 16'h0);

    // 6: reset lands one cycle before the start pulse; button held through it
    btn_start = 1'b1;
    k = cyc + 1;
    tick(k + DEB + 1 - cyc - 1);
    reset = 1'b0;
    tick(3);
    check("reset_mid_outputs", 16'({start, stop, clr, running, lap_valid, lap_value}), 16'h0);
    reset   = 1'b1;
    exp_lap = '0;
    tick(15);
    check("held_through_reset", 16'(running), 16'h0);
    btn_start = 1'b0;
    tick(12);
    count_in = 4'hf;
    press(1'b0, 10, 1'b1, 3'b100, 1'b1, 1'b0);
    if (LAP) exp_lap = 4'hf;
    press(1'b1, 10, 1'b1, 3'b010, 1'b0, LAP);
    check("final_lap_value", 16'(lap_value), 16'(exp_lap));

    tick(10);
    check("scoreboard_empty", 16'(sb.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sr_cmd_gen
`default_nettype wire

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
Command-side partner of the start/stop counter. Turns two raw push-buttons into clean single-cycle start, stop and clear command pulses for the counter. Tracks run state and, optionally, captures the counter's value at each stop. Sits between board I/O and the counter; its outputs drive the counter's start/stop inputs directly.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change (>=1)
DEB_W, 3, debounce counter width; must hold DEB_CYCLES-1
CNT_W, 4, width of counter value fed back for lap capture

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
btn_start  input  1  raw start button, asynchronous, active-high
btn_stop  input  1  raw stop button, asynchronous, active-high
count_in  input  CNT_W  current counter value
start  output  1  one-cycle start command pulse
stop  output  1  one-cycle stop command pulse
clr  output  1  one-cycle clear command pulse
running  output  1  high while in RUN
lap_value  output  CNT_W  count captured at last stop
lap_valid  output  1  one-cycle strobe: lap_value updated

Behaviour:
- Reset: sampled on clk while reset==0. Forces state IDLE, start/stop/clr/running/lap_valid=0, lap_value=0, synchronizers=0, debounced levels=0, debounce counters=0. Reset mid-operation aborts any in-flight pulse; no command is emitted on the reset-release cycle.
- Per button: 2-flop synchronizer. Debounce counter clears whenever the synchronized sample equals the debounced level. It increments while they differ. On the DEB_CYCLES-th consecutive differing sample, the debounced level takes the sample and the counter clears.
- Press event = debounced rising edge (level & ~level_d1). One event per press; release produces no event.
- Latency: first edge k samples btn high and input stays stable → command output high after edge k+DEB_CYCLES+2, for exactly one cycle. Glitches shorter than DEB_CYCLES samples are ignored.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: start event → RUN, pulse start. Stop event ignored.
  - RUN: stop event → HOLD, pulse stop. Start event ignored.
  - HOLD: start event → RUN, pulse start (resume). Stop event → IDLE, pulse clr.
- Simultaneous start and stop events in the same cycle: stop has priority. Start is discarded, not queued.
- Outputs are registered. At most one of start/stop/clr is high in any cycle.
- running = (state==RUN), registered with the state.

Optional Feature:
Macro SR_LAP_CAPTURE_EN.
- Defined: on the edge that asserts stop, lap_value <= count_in. lap_valid is high in the same cycle as stop. lap_value holds until the next stop or reset. clr does not alter lap_value.
- Undefined: lap_value tied 0 and lap_valid tied 0. Ports remain present. No capture register is synthesized.

Decomposition:
- Package sr_pkg: state encoding (IDLE=2'b00, RUN=2'b01, HOLD=2'b10) and default CNT_W.
- Sub-module sr_debounce (synchronizer + debounce counter + edge detect, outputs a press pulse), parameterized by DEB_CYCLES/DEB_W and instantiated once per button. The FSM and lap register stay in sr_cmd_gen.

Test Plan:
1. Reset low 3 cycles then high, buttons idle 20 cycles → all outputs 0, running=0.
2. DEB_CYCLES=4: btn_start high from edge 10, held 10 cycles → start high only after edge 16, running=1 from edge 16, no further pulses on release.
3. In RUN, 2-cycle btn_stop glitch → no stop pulse, running stays 1. Then a clean stop press with count_in=4'h9 → stop single pulse, running=0. With SR_LAP_CAPTURE_EN: lap_value=4'h9 and lap_valid coincident with stop.
4. HOLD: start press → start pulse, RUN. Stop press → HOLD. Second stop press → clr pulse, IDLE. lap_value unchanged by clr.
5. In IDLE, both buttons asserted at the same edge and held → stop event wins and is ignored in IDLE. No start/stop/clr, state stays IDLE.
6. Assert reset one cycle before an expected start pulse → no start pulse, state IDLE. Release reset with button still held → no event until button released and re-pressed.
